// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, port owner,
// the registered memory command and the width of the data-streak counter.
package mem_arb_pkg;

   localparam int STREAK_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } state_e;

   typedef enum logic [1:0] {
      NONE,
      FETCH,
      DATA
   } owner_e;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } cmd_t;

endpackage

// File: rtl/arb_streak_prio.sv
// Grant decision between fetch and data. Data normally wins, but a bounded
// streak counter forces a fetch grant once data has won MAX_D_STREAK times
// in a row while fetch was waiting.
module arb_streak_prio
   import mem_arb_pkg::*;
#(
   parameter int MAX_D_STREAK = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   if_req_i,
   input  logic   d_req_i,
   input  logic   grant_i,
   output owner_e winner_o
);

   localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(MAX_D_STREAK);

   logic [STREAK_W-1:0] streak_q;
   logic [STREAK_W-1:0] streak_d;
   logic                fetchForced;

   // Pick the winner: data unless fetch is waiting and the streak is used up.
   always_comb begin
      fetchForced = if_req_i && (streak_q == StreakMax);
      winner_o    = NONE;
      if (d_req_i && !fetchForced) begin
         winner_o = DATA;
      end else if (if_req_i) begin
         winner_o = FETCH;
      end
   end

   // Count data wins that made fetch wait; any other grant restarts the count.
   always_comb begin
      streak_d = streak_q;
      if (grant_i) begin
         if ((winner_o == DATA) && if_req_i) begin
            if (streak_q != StreakMax) begin
               streak_d = streak_q + STREAK_W'(1);
            end
         end else begin
            streak_d = '0;
         end
      end
   end

   // Streak counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// One transaction is outstanding at a time: IDLE arbitrates and registers the
// command, REQ holds it until the memory accepts, RESP waits for the reply,
// which is then routed to whichever requester owns the port.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_D_STREAK = 4,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_wstrb,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   output logic [3:0]        m_wstrb,
   input  logic              m_ready,
   input  logic              m_rvalid,
   input  logic [31:0]       m_rdata,
   output logic              busy,
   output logic              prot_err
);

   state_e      state_q,    state_d;
   owner_e      owner_q,    owner_d;
   cmd_t        cmd_q,      cmd_d;
   logic        ifGnt_q,    ifGnt_d;
   logic        dGnt_q,     dGnt_d;
   logic        ifRvalid_q, ifRvalid_d;
   logic        dRvalid_q,  dRvalid_d;
   logic [31:0] ifRdata_q,  ifRdata_d;
   logic [31:0] dRdata_q,   dRdata_d;
   logic        protErr_q,  protErr_d;
   logic        grantStb;
   logic        complete;
   owner_e      winner;

   assign grantStb = (state_q == IDLE) && (if_req || d_req);

   arb_streak_prio #(
      .MAX_D_STREAK(MAX_D_STREAK)
   ) uPrio (
      .clk      (clk),
      .rst      (rst),
      .if_req_i (if_req),
      .d_req_i  (d_req),
      .grant_i  (grantStb),
      .winner_o (winner)
   );

   // Next-state and registered-output logic for the transaction sequencer.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cmd_d      = cmd_q;
      ifGnt_d    = 1'b0;
      dGnt_d     = 1'b0;
      ifRvalid_d = 1'b0;
      dRvalid_d  = 1'b0;
      ifRdata_d  = ifRdata_q;
      dRdata_d   = dRdata_q;
      protErr_d  = protErr_q;
      complete   = 1'b0;

      case (state_q)
         IDLE: begin
            if (m_rvalid) begin
               protErr_d = 1'b1;
            end
            if (grantStb && (winner == FETCH)) begin
               cmd_d.we    = 1'b0;
               cmd_d.addr  = 32'(if_addr);
               cmd_d.wdata = '0;
               cmd_d.wstrb = '0;
               owner_d     = FETCH;
               ifGnt_d     = 1'b1;
               state_d     = REQ;
            end else if (grantStb && (winner == DATA)) begin
               cmd_d.we    = d_we;
               cmd_d.addr  = 32'(d_addr);
               cmd_d.wdata = d_wdata;
               cmd_d.wstrb = d_wstrb;
               owner_d     = DATA;
               dGnt_d      = 1'b1;
               state_d     = REQ;
            end
         end
         REQ: begin
            if (m_ready) begin
               if (m_rvalid) begin
                  complete = 1'b1;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (m_rvalid) begin
               complete = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (complete) begin
         state_d = IDLE;
         owner_d = NONE;
         if (owner_q == FETCH) begin
            ifRdata_d  = m_rdata;
            ifRvalid_d = 1'b1;
         end else if (owner_q == DATA) begin
            dRdata_d  = cmd_q.we ? 32'd0 : m_rdata;
            dRvalid_d = 1'b1;
         end
      end
   end

   // State, command and response registers; reset drops any transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= NONE;
         cmd_q      <= '0;
         ifGnt_q    <= 1'b0;
         dGnt_q     <= 1'b0;
         ifRvalid_q <= 1'b0;
         dRvalid_q  <= 1'b0;
         ifRdata_q  <= '0;
         dRdata_q   <= '0;
         protErr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cmd_q      <= cmd_d;
         ifGnt_q    <= ifGnt_d;
         dGnt_q     <= dGnt_d;
         ifRvalid_q <= ifRvalid_d;
         dRvalid_q  <= dRvalid_d;
         ifRdata_q  <= ifRdata_d;
         dRdata_q   <= dRdata_d;
         protErr_q  <= protErr_d;
      end
   end

   assign if_gnt    = ifGnt_q;
   assign d_gnt     = dGnt_q;
   assign if_rvalid = ifRvalid_q;
   assign d_rvalid  = dRvalid_q;
   assign if_rdata  = ifRdata_q;
   assign d_rdata   = dRdata_q;
   assign m_req     = (state_q == REQ);
   assign m_we      = cmd_q.we;
   assign m_addr    = cmd_q.addr[ADDR_W-1:0];
   assign m_wdata   = cmd_q.wdata;
   assign m_wstrb   = cmd_q.wstrb;
   assign busy      = (state_q != IDLE);
   assign prot_err  = protErr_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between instruction fetch and data load/store in the RV32I core.
- Arbitrates between the two requesters and sequences one outstanding transaction at a time through a request/accept/response handshake.
- Returns read data or a write acknowledge to whichever requester was granted.
- Prevents fetch starvation under back-to-back data traffic with a bounded data-priority streak.

Parameters:
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch is pending before fetch is forced to win; legal range 1..15.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request; held with d_* until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: load data valid or store acknowledged
- d_rdata  out  32  load data; 0 on store acknowledge
- m_req  out  1  memory request, held until m_ready
- m_we, m_addr, m_wdata, m_wstrb  out  1/ADDR_W/32/4  memory command, stable while m_req=1
- m_ready  in  1  memory accepts command this cycle
- m_rvalid  in  1  memory response (read data or write ack)
- m_rdata  in  32  memory read data
- busy  out  1  state != IDLE
- prot_err  out  1  sticky: m_rvalid received in IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; owner NONE; streak counter 0. Reset mid-transaction abandons the transaction silently; no late rvalid is forwarded.
- FSM IDLE:
  - If any request is present, arbitrate at the edge, register the winner's command onto m_*, pulse the winner's gnt, and go to REQ. m_req and gnt both rise the cycle after sampling.
  - Otherwise stay in IDLE.
- Arbitration: data wins unless if_req=1 and streak==MAX_D_STREAK, in which case fetch wins.
- Streak counter:
  - A data grant while if_req=1 increments it, saturating at MAX_D_STREAK.
  - A fetch grant clears it.
  - A data grant with if_req=0 clears it.
- FSM REQ: hold m_* stable.
  - m_ready=1 and m_rvalid=0: go to RESP; m_req drops next cycle.
  - m_ready=1 and m_rvalid=1: zero-latency completion; forward the response and go to IDLE.
- FSM RESP: wait on m_rvalid. On m_rvalid, register m_rdata to the owner's rdata, pulse the owner's rvalid next cycle, and go to IDLE.
- Response width rules:
  - Store completions drive d_rdata=0.
  - The non-owner's rdata holds its previous value.
- Minimum turnaround: one IDLE cycle between a completion and the next m_req. Best-case transaction is 3 cycles from req sampling to rvalid.
- m_rvalid in REQ without m_ready is ignored.
- m_rvalid in IDLE sets prot_err; it clears only on rst.
- Requester drop: a request deasserted before its gnt is legal and simply not served. Requests are sampled only in IDLE.
- Simultaneous requests: exactly one gnt fires per arbitration; the loser keeps its req asserted and is re-arbitrated at the next IDLE.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, REQ, RESP}
  - owner enum {NONE, FETCH, DATA}
  - command struct fields (we, addr, wdata, wstrb)
  - streak counter width constant (4)
- One natural sub-module, arb_streak_prio: holds the streak counter and the grant decision. Inputs if_req, d_req, grant strobe; output winner.

Test Plan:
- Fetch-only, single-cycle memory: if_req=1, addr=0x100, m_ready=1 and m_rvalid=1 on the first REQ cycle, rdata=0x00500093 -> if_gnt at cycle 1, if_rvalid at cycle 2 with if_rdata=0x00500093, busy low at cycle 2.
- Store then load with 2-cycle memory latency: d_we=1, addr=0x40, wdata=0xDEADBEEF, wstrb=0xF, then a load from 0x40 returning 0xDEADBEEF:
  - Expect m_wstrb=0xF on the store.
  - Expect d_rvalid with d_rdata=0 for the store.
  - Expect d_rvalid with d_rdata=0xDEADBEEF for the load.
- Contention, MAX_D_STREAK=4: if_req and d_req held continuously -> grant order D,D,D,D,F,D,D,D,D,F; streak returns to 0 after each F.
- Reset mid-operation: assert rst in RESP, then deassert; memory then pulses m_rvalid -> no rvalid forwarded, state IDLE, prot_err=1.
- Stalled accept: m_ready held low 5 cycles in REQ while d_addr changes upstream -> m_addr and m_req stay constant at the granted value; completes normally once m_ready=1.
- Requester drop: if_req pulses for 1 cycle while busy -> no if_gnt is issued.
